// File: rtl/totp_digit_sequencer_if.sv
// Code handoff from the TOTP generator into the display sequencer.
// One transfer per rising edge where code_valid and code_ready are both high.
// The consumer drops code_ready while it is converting or showing; it does not queue.
interface totp_digit_sequencer_if;
  logic        code_valid;
  logic [19:0] code;
  logic        code_ready;

  modport master (output code_valid, output code, input code_ready);
  modport slave  (input code_valid, input code, output code_ready);
endinterface

// File: rtl/totp_digit_sequencer.sv
// Converts a 20-bit TOTP code to six BCD digits and cycles them MSD-first on one 7-seg output.
// Latency: transfer at edge T, first digit on segments after edge T+21 (20 conversion steps + output register).
// Backpressure: code_ready high only in IDLE/GAP; codes offered while not ready are dropped.
module totp_digit_sequencer #(
  parameter int DWELL_CYCLES = 1000,
  parameter int GAP_CYCLES   = 2000
) (
  input  logic                    clk,
  input  logic                    rst,
  totp_digit_sequencer_if.slave   cin,
  output logic [6:0]              segments,
  output logic [2:0]              digit_idx,
  output logic                    busy
);

  localparam int DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_CYCLES - 1);
  localparam logic [19:0]   CODE_LIMIT = 20'd1000000;
  localparam logic [6:0]    SEG_DASH   = 7'h40;

  typedef enum logic [1:0] {IDLE, CONVERT, SHOW, GAP} state_t;

  state_t          state, state_nxt;
  logic            xfer;
  logic [4:0]      cvt_cnt;
  logic [DW-1:0]   dwell_cnt;
  logic [GW-1:0]   gap_cnt;
  logic [2:0]      idx;
  logic [19:0]     bin;
  logic [23:0]     bcd;
  logic [23:0]     bcd_adj;
  logic [23:0]     bcd_nxt;
  logic            oor;
  logic [3:0]      cur_digit;
  logic            cvt_done, dwell_done, gap_done;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  assign cin.code_ready = (state == IDLE) || (state == GAP);
  assign busy           = (state != IDLE);
  assign xfer           = cin.code_valid && cin.code_ready;
  assign cvt_done       = (cvt_cnt == 5'd19);
  assign dwell_done     = (dwell_cnt == DWELL_LAST);
  assign gap_done       = (gap_cnt == GAP_LAST);

  // One double-dabble step: add 3 to every digit >= 5, then shift in the next binary bit.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 6; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
    end
    bcd_nxt = (bcd_adj << 1) | {23'd0, bin[19]};
  end

  // Select the BCD digit for the current index; index 0 is the most significant digit.
  always_comb begin
    cur_digit = 4'd0;
    case (idx)
      3'd0:    cur_digit = bcd[23:20];
      3'd1:    cur_digit = bcd[19:16];
      3'd2:    cur_digit = bcd[15:12];
      3'd3:    cur_digit = bcd[11:8];
      3'd4:    cur_digit = bcd[7:4];
      3'd5:    cur_digit = bcd[3:0];
      default: cur_digit = 4'd0;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; a new code in GAP restarts conversion instead of repeating.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (xfer) state_nxt = CONVERT;
      CONVERT: if (cvt_done) state_nxt = SHOW;
      SHOW:    if (dwell_done && (idx == 3'd5)) state_nxt = GAP;
      GAP: begin
        if (xfer)          state_nxt = CONVERT;
        else if (gap_done) state_nxt = SHOW;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Code latch, conversion shifter and dwell/gap/index counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      bin       <= '0;
      bcd       <= '0;
      oor       <= 1'b0;
      cvt_cnt   <= '0;
      dwell_cnt <= '0;
      gap_cnt   <= '0;
      idx       <= '0;
    end else if (xfer) begin
      bin       <= cin.code;
      bcd       <= '0;
      oor       <= (cin.code >= CODE_LIMIT);
      cvt_cnt   <= '0;
      dwell_cnt <= '0;
      gap_cnt   <= '0;
      idx       <= '0;
    end else begin
      case (state)
        CONVERT: begin
          bcd <= bcd_nxt;
          bin <= bin << 1;
          if (cvt_done) begin
            cvt_cnt   <= '0;
            dwell_cnt <= '0;
            idx       <= '0;
          end else begin
            cvt_cnt <= cvt_cnt + 5'd1;
          end
        end
        SHOW: begin
          if (dwell_done) begin
            dwell_cnt <= '0;
            if (idx == 3'd5) begin
              idx     <= '0;
              gap_cnt <= '0;
            end else begin
              idx <= idx + 3'd1;
            end
          end else begin
            dwell_cnt <= dwell_cnt + 1'b1;
          end
        end
        GAP: begin
          if (gap_done) begin
            gap_cnt   <= '0;
            dwell_cnt <= '0;
            idx       <= '0;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Registered display outputs; blank with index 0 outside SHOW.
  always_ff @(posedge clk) begin
    if (rst) begin
      segments  <= '0;
      digit_idx <= '0;
    end else if (state == SHOW) begin
      segments  <= oor ? SEG_DASH : seg_decode(cur_digit);
      digit_idx <= idx;
    end else begin
      segments  <= '0;
      digit_idx <= '0;
    end
  end

endmodule
